// File: rtl/mux4_scan_pkg.sv
// Shared types and select-order constants for the 4:1 scan serializer.
// Build option: MSB_FIRST_EN reverses the channel order (channel 3 first).
package mux4_scan_pkg;

    localparam int NCH   = 4;
    localparam int SEL_W = 2;

    typedef enum logic {IDLE, SEND} scan_state_t;

    // Stepping by 3 in 2-bit arithmetic is a decrement.
`ifdef MSB_FIRST_EN
    localparam logic [SEL_W-1:0] SEL_FIRST = 2'd3;
    localparam logic [SEL_W-1:0] SEL_LAST  = 2'd0;
    localparam logic [SEL_W-1:0] SEL_STEP  = 2'd3;
`else
    localparam logic [SEL_W-1:0] SEL_FIRST = 2'd0;
    localparam logic [SEL_W-1:0] SEL_LAST  = 2'd3;
    localparam logic [SEL_W-1:0] SEL_STEP  = 2'd1;
`endif

endpackage

// File: rtl/mux4_bit.sv
// Combinational 4:1 bit multiplexer: y is the held bit picked by select s.
module mux4_bit
    import mux4_scan_pkg::*;
(
    input  logic [NCH-1:0]   hold,
    input  logic [SEL_W-1:0] s,
    output logic             y
);

    assign y = hold[s];

endmodule

// File: rtl/mux4_scan_serializer.sv
// Captures a 4-bit word via valid/ready and emits it one bit per beat.
// Build option: MSB_FIRST_EN (channel 3 emitted first, reset select 2'b11).
module mux4_scan_serializer
    import mux4_scan_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   i,
    input  logic             i_valid,
    output logic             i_ready,
    output logic [SEL_W-1:0] s,
    output logic             y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             y_last
);

    generate
        if (NCH != 4 || SEL_W != $clog2(NCH)) begin : g_bad_cfg
            $error("mux4_scan_serializer supports exactly 4 channels with a 2-bit select");
        end
    endgenerate

    scan_state_t    state;
    logic [NCH-1:0] hold;

    // The LAST check comes before the step, so the select never wraps mid-word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            hold    <= '0;
            s       <= SEL_FIRST;
            i_ready <= 1'b1;
            y_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid && i_ready) begin
                        hold    <= i;
                        s       <= SEL_FIRST;
                        state   <= SEND;
                        i_ready <= 1'b0;
                        y_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (y_valid && y_ready) begin
                        if (s == SEL_LAST) begin
                            s       <= SEL_FIRST;
                            state   <= IDLE;
                            i_ready <= 1'b1;
                            y_valid <= 1'b0;
                        end else begin
                            s <= s + SEL_STEP;
                        end
                    end
                end
            endcase
        end
    end

    assign y_last = y_valid && (s == SEL_LAST);

    mux4_bit u_mux (
        .hold (hold),
        .s    (s),
        .y    (y)
    );

endmodule

// File: tb/tb_mux4_scan_serializer.sv
// Scoreboard bench for mux4_scan_serializer; honours MSB_FIRST_EN like the design.
module tb_mux4_scan_serializer;

    logic       clk;
    logic       rst;
    logic [3:0] i;
    logic       i_valid;
    logic       i_ready;
    logic [1:0] s;
    logic       y;
    logic       y_valid;
    logic       y_ready;
    logic       y_last;

    int vectors     = 0;
    int miscompares = 0;

    // Each entry is {s, y, y_last} expected for one beat.
    logic [3:0] sb[$];

`ifdef MSB_FIRST_EN
    localparam logic [1:0] FIRST_CH = 2'd3;
`else
    localparam logic [1:0] FIRST_CH = 2'd0;
`endif

    mux4_scan_serializer dut (
        .clk     (clk),
        .rst     (rst),
        .i       (i),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .s       (s),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .y_last  (y_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] chan_of_beat(int k);
`ifdef MSB_FIRST_EN
        return 2'(3 - k);
`else
        return 2'(k);
`endif
    endfunction

    function automatic void push_word(logic [3:0] w);
        for (int k = 0; k < 4; k++) begin
            logic [1:0] ch;
            ch = chan_of_beat(k);
            sb.push_back({ch, w[ch], (k == 3)});
        end
    endfunction

    task automatic test_reset();
        #2;
        vectors++;
        if ({i_ready, y_valid, s, y, y_last} !== {1'b1, 1'b0, FIRST_CH, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset_por: got rdy=%b vld=%b s=%0d y=%b last=%b, expected rdy=1 vld=0 s=%0d y=0 last=0",
                     i_ready, y_valid, s, y, y_last, FIRST_CH);
        end
        @(posedge clk); #1;
        rst = 1'b0; i = 4'hF; i_valid = 1'b1; y_ready = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        vectors++;
        if (y_valid !== 1'b1 || y !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_pre_send: got vld=%b y=%b, expected vld=1 y=1", y_valid, y);
        end
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        vectors++;
        if ({i_ready, y_valid, s, y, y_last} !== {1'b1, 1'b0, FIRST_CH, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_send: got rdy=%b vld=%b s=%0d y=%b last=%b, expected rdy=1 vld=0 s=%0d y=0 last=0",
                     i_ready, y_valid, s, y, y_last, FIRST_CH);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (y_valid !== 1'b0 || i_ready !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL reset_no_replay: got vld=%b rdy=%b, expected vld=0 rdy=1", y_valid, i_ready);
            end
        end
    endtask

    task automatic test_basic();
        int         acc_c  = -1;
        int         last_c = -1;
        logic [3:0] e;
        y_ready = 1'b1;
        for (int c = 0; c < 16 && last_c < 0; c++) begin
            @(posedge clk); #1;
            i = 4'b1011; i_valid = (acc_c < 0);
            @(negedge clk);
            if (i_valid && i_ready) begin push_word(i); acc_c = c; end
            if (y_valid && y_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL basic_beat: got unexpected beat s=%0d y=%b, expected none", s, y);
                end else begin
                    e = sb.pop_front();
                    if ({s, y, y_last} !== e) begin
                        miscompares++;
                        $display("[TB] FAIL basic_beat: got s=%0d y=%b last=%b, expected s=%0d y=%b last=%b",
                                 s, y, y_last, e[3:2], e[1], e[0]);
                    end
                    if (e[0]) last_c = c;
                end
            end
        end
        vectors++;
        if (last_c < 0 || acc_c < 0 || last_c - acc_c != 4) begin
            miscompares++;
            $display("[TB] FAIL basic_latency: got accept=%0d last=%0d, expected last 4 cycles after accept", acc_c, last_c);
        end
        @(posedge clk); #1;
        i_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (i_ready !== 1'b1 || y_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL basic_idle: got rdy=%b vld=%b, expected rdy=1 vld=0", i_ready, y_valid);
        end
    endtask

    task automatic test_backpressure();
        int         acc_c  = -1;
        int         last_c = -1;
        int         beats  = 0;
        int         stalls = 0;
        logic [3:0] e;
        for (int c = 0; c < 20 && last_c < 0; c++) begin
            @(posedge clk); #1;
            i = 4'b0110; i_valid = (acc_c < 0);
            y_ready = !(beats == 1 && stalls < 3);
            if (!y_ready) stalls++;
            @(negedge clk);
            if (i_valid && i_ready) begin push_word(i); acc_c = c; end
            if (acc_c >= 0 && acc_c != c && !y_ready) begin
                vectors++;
                if (sb.size() == 0 || y_valid !== 1'b1 || {s, y, y_last} !== sb[0]) begin
                    miscompares++;
                    $display("[TB] FAIL bp_stall: got vld=%b s=%0d y=%b last=%b, expected held beat %0d",
                             y_valid, s, y, y_last, beats + 1);
                end
            end
            if (y_valid && y_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL bp_beat: got unexpected beat s=%0d y=%b, expected none", s, y);
                end else begin
                    e = sb.pop_front();
                    beats++;
                    if ({s, y, y_last} !== e) begin
                        miscompares++;
                        $display("[TB] FAIL bp_beat: got s=%0d y=%b last=%b, expected s=%0d y=%b last=%b",
                                 s, y, y_last, e[3:2], e[1], e[0]);
                    end
                    if (e[0]) last_c = c;
                end
            end
        end
        vectors++;
        if (last_c < 0 || last_c - acc_c != 7) begin
            miscompares++;
            $display("[TB] FAIL bp_timeout: got accept=%0d last=%0d, expected last 7 cycles after accept", acc_c, last_c);
        end
        @(posedge clk); #1;
        i_valid = 1'b0; y_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [3:0] words[2];
        int         acc_c[2];
        int         last_c[2];
        int         n_acc  = 0;
        int         n_done = 0;
        logic [3:0] e;
        words[0] = 4'hA; words[1] = 4'h5;
        acc_c[0] = -1; acc_c[1] = -1; last_c[0] = -1; last_c[1] = -1;
        y_ready = 1'b1;
        for (int c = 0; c < 30 && n_done < 2; c++) begin
            @(posedge clk); #1;
            i = words[(n_acc < 2) ? n_acc : 1]; i_valid = (n_acc < 2);
            @(negedge clk);
            if (i_valid && i_ready) begin push_word(i); acc_c[n_acc] = c; n_acc++; end
            if (y_valid && y_ready) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL b2b_beat: got unexpected beat s=%0d y=%b, expected none", s, y);
                end else begin
                    e = sb.pop_front();
                    if ({s, y, y_last} !== e) begin
                        miscompares++;
                        $display("[TB] FAIL b2b_beat: got s=%0d y=%b last=%b, expected s=%0d y=%b last=%b",
                                 s, y, y_last, e[3:2], e[1], e[0]);
                    end
                    if (e[0]) begin last_c[n_done] = c; n_done++; end
                end
            end
        end
        vectors++;
        if (n_done < 2 || acc_c[1] - last_c[0] != 1) begin
            miscompares++;
            $display("[TB] FAIL b2b_gap: got second accept=%0d first last=%0d, expected gap of 1", acc_c[1], last_c[0]);
        end
        vectors++;
        if (n_done < 2 || last_c[1] - acc_c[0] != 9) begin
            miscompares++;
            $display("[TB] FAIL b2b_total: got span=%0d, expected 9 (10 cycles)", last_c[1] - acc_c[0]);
        end
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic test_ignore_in_send();
        int         acc_c  = -1;
        int         last_c = -1;
        logic [3:0] e;
        y_ready = 1'b1;
        for (int c = 0; c < 16 && last_c < 0; c++) begin
            @(posedge clk); #1;
            if (acc_c < 0) begin
                i = 4'b1001; i_valid = 1'b1;
            end else begin
                i = 4'($urandom_range(0, 15)); i_valid = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (i_valid && i_ready) begin push_word(i); acc_c = c; end
            if (y_valid && y_ready) begin
                vectors++;
                if (i_ready !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL ign_ready: got rdy=%b during beat, expected 0", i_ready);
                end
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL ign_beat: got unexpected beat s=%0d y=%b, expected none", s, y);
                end else begin
                    e = sb.pop_front();
                    if ({s, y, y_last} !== e) begin
                        miscompares++;
                        $display("[TB] FAIL ign_beat: got s=%0d y=%b last=%b, expected s=%0d y=%b last=%b",
                                 s, y, y_last, e[3:2], e[1], e[0]);
                    end
                    if (e[0]) last_c = c;
                end
            end
        end
        vectors++;
        if (last_c < 0) begin
            miscompares++;
            $display("[TB] FAIL ign_timeout: got no final beat, expected one within 16 cycles");
        end
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i = 4'h0; i_valid = 1'b0; y_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_ignore_in_send();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL sb_drain: got %0d pending beats, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
